// File: rtl/stream_mux_n_1_if.sv
// Handshake/bus bundle for stream_mux_n_1: N_CH producer channels in, one registered stream out.
// STREAM_MUX_LOCK_EN adds the per-channel in_last and the registered out_last.
interface stream_mux_n_1_if #(
    parameter int N_CH = 8,
    parameter int W    = 8
);
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH*W-1:0] in_data;
    logic [N_CH-1:0]   in_valid;
    logic [N_CH-1:0]   in_ready;
    logic [SEL_W-1:0]  sel;
    logic              mode;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic [SEL_W-1:0]  out_ch;
`ifdef STREAM_MUX_LOCK_EN
    logic [N_CH-1:0]   in_last;
    logic              out_last;

    modport master (output in_data, in_valid, in_last, sel, mode, out_ready,
                    input  in_ready, out_data, out_valid, out_ch, out_last);
    modport slave  (input  in_data, in_valid, in_last, sel, mode, out_ready,
                    output in_ready, out_data, out_valid, out_ch, out_last);
`else
    modport master (output in_data, in_valid, sel, mode, out_ready,
                    input  in_ready, out_data, out_valid, out_ch);
    modport slave  (input  in_data, in_valid, sel, mode, out_ready,
                    output in_ready, out_data, out_valid, out_ch);
`endif
endinterface

// File: rtl/stream_mux_n_1.sv
// N_CH-to-1 valid/ready stream mux with fixed-select or round-robin grant and a one-deep output register.
// STREAM_MUX_LOCK_EN: round-robin grants stay locked to a channel until its in_last beat transfers.
module stream_mux_n_1 #(
    parameter int N_CH = 8,
    parameter int W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    stream_mux_n_1_if.slave     mux_if
);
    localparam int SEL_W = $clog2(N_CH);

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             load_en, granted, xfer;
    logic [SEL_W-1:0] grant, cand;
`ifdef STREAM_MUX_LOCK_EN
    logic             lock_q, lock_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
    logic             out_last_q, out_last_d;
`endif

    assign load_en = !out_valid_q || mux_if.out_ready;

    always_comb begin
        granted = 1'b0;
        grant   = '0;
        cand    = '0;
        if (!mux_if.mode) begin
            if (int'(mux_if.sel) < N_CH && mux_if.in_valid[mux_if.sel]) begin
                granted = 1'b1;
                grant   = mux_if.sel;
            end
        end
`ifdef STREAM_MUX_LOCK_EN
        else if (lock_q) begin
            granted = mux_if.in_valid[lock_ch_q];
            grant   = lock_ch_q;
        end
`endif
        else begin
            // Search begins one past the last winner, wrapping modulo N_CH
            for (int k = 1; k <= N_CH; k++) begin
                cand = SEL_W'((int'(rr_ptr_q) + k) % N_CH);
                if (!granted && mux_if.in_valid[cand]) begin
                    granted = 1'b1;
                    grant   = cand;
                end
            end
        end
    end

    // rst gates the handshake so no beat is accepted while the register is held clear
    assign xfer            = granted && load_en && !rst;
    assign mux_if.in_ready = xfer ? (N_CH'(1) << grant) : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef STREAM_MUX_LOCK_EN
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
        out_last_d  = out_last_q;
`endif
        if (out_valid_q && mux_if.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_if.in_data[int'(grant)*W +: W];
            out_ch_d    = grant;
`ifdef STREAM_MUX_LOCK_EN
            out_last_d  = mux_if.in_last[grant];
            if (mux_if.mode) begin
                if (mux_if.in_last[grant]) begin
                    lock_d   = 1'b0;
                    rr_ptr_d = grant;
                end else begin
                    lock_d    = 1'b1;
                    lock_ch_d = grant;
                end
            end
`else
            if (mux_if.mode) begin
                rr_ptr_d = grant;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= SEL_W'(N_CH - 1);
`ifdef STREAM_MUX_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
            out_last_q  <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef STREAM_MUX_LOCK_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
            out_last_q  <= out_last_d;
`endif
        end
    end

    assign mux_if.out_valid = out_valid_q;
    assign mux_if.out_data  = out_data_q;
    assign mux_if.out_ch    = out_ch_q;
`ifdef STREAM_MUX_LOCK_EN
    assign mux_if.out_last  = out_last_q;
`endif
endmodule

// File: tb/tb_stream_mux_n_1.sv
// Bench for stream_mux_n_1: directed vector table, corner sequences, and random traffic
// against a reference model plus an in-order beat scoreboard.
module tb_stream_mux_n_1;
    localparam int N  = 8;
    localparam int W  = 8;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    stream_mux_n_1_if #(.N_CH(N), .W(W)) mux_if ();
    stream_mux_n_1 #(.N_CH(N), .W(W)) dut (.clk(clk), .rst(rst), .mux_if(mux_if));

    always #5 clk = ~clk;

    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_ch;
    int           m_rr;
    logic         m_last;
    bit           m_lock;
    int           m_lock_ch;

    typedef struct {
        int           ch;
        logic [W-1:0] data;
    } beat_t;
    beat_t sb[$];

    typedef struct {
        logic [N-1:0]  valid;
        logic [SW-1:0] sel;
        logic          mode;
        logic          ordy;
        logic [N-1:0]  exp_rdy;
        logic          exp_valid;
        logic [W-1:0]  exp_data;
        logic [SW-1:0] exp_ch;
    } vec_t;
    vec_t tbl[9];

    logic [N*W-1:0] pat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid   = 1'b0;
        m_data    = '0;
        m_ch      = 0;
        m_rr      = N - 1;
        m_last    = 1'b0;
        m_lock    = 1'b0;
        m_lock_ch = 0;
        sb.delete();
    endtask

    function automatic int model_grant(input logic [N-1:0] v, input int s, input logic m);
        if (!m) return (s < N && v[s]) ? s : -1;
        if (m_lock) return v[m_lock_ch] ? m_lock_ch : -1;
        for (int k = 1; k <= N; k++) begin
            if (v[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic drive(input logic [N*W-1:0] d, input logic [N-1:0] v, input logic [SW-1:0] s,
                         input logic m, input logic ordy, input logic [N-1:0] last);
        mux_if.in_data   = d;
        mux_if.in_valid  = v;
        mux_if.sel       = s;
        mux_if.mode      = m;
        mux_if.out_ready = ordy;
`ifdef STREAM_MUX_LOCK_EN
        mux_if.in_last   = last;
`else
        if (last != '0) m_last = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive('0, '0, '0, 1'b0, 1'b0, '0);
        #1;
        check("rst_out_valid", mux_if.out_valid, 0);
        check("rst_out_data", mux_if.out_data, 0);
        check("rst_out_ch", mux_if.out_ch, 0);
        check("rst_in_ready", mux_if.in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: predict grant, check handshake and scoreboard, advance model, check outputs.
    task automatic cycle(input logic [N*W-1:0] d, input logic [N-1:0] v, input logic [SW-1:0] s,
                         input logic m, input logic ordy, input logic [N-1:0] last);
        int           g;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] hs;
        beat_t        b;
        drive(d, v, s, m, ordy, last);
        #1;
        g = model_grant(v, int'(s), m);
        exp_rdy = ((!m_valid || ordy) && g >= 0) ? (N'(1) << g) : '0;
        check("in_ready", mux_if.in_ready, exp_rdy);
        if (mux_if.out_valid && ordy) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_pop: beat ch%0d drained with nothing accepted", mux_if.out_ch);
            end else begin
                b = sb.pop_front();
                check("sb_ch", mux_if.out_ch, b.ch);
                check("sb_data", mux_if.out_data, b.data);
            end
        end
        hs = mux_if.in_ready & v;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) sb.push_back('{ch: i, data: d[i*W +: W]});
        end
        if (m_valid && ordy) m_valid = 1'b0;
        if (exp_rdy != '0) begin
            m_valid = 1'b1;
            m_data  = d[g*W +: W];
            m_ch    = g;
            m_last  = last[g];
            if (m) begin
`ifdef STREAM_MUX_LOCK_EN
                if (last[g]) begin
                    m_lock = 1'b0;
                    m_rr   = g;
                end else begin
                    m_lock    = 1'b1;
                    m_lock_ch = g;
                end
`else
                m_rr = g;
`endif
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", mux_if.out_valid, m_valid);
        check("out_data", mux_if.out_data, m_data);
        check("out_ch", mux_if.out_ch, m_ch);
`ifdef STREAM_MUX_LOCK_EN
        check("out_last", mux_if.out_last, m_last);
`endif
    endtask

    initial begin
        for (int i = 0; i < N; i++) pat[i*W +: W] = 8'hA2 + 8'(i);

        tbl[0] = '{8'h08, 3'd3, 1'b0, 1'b1, 8'h08, 1'b1, 8'hA5, 3'd3};
        tbl[1] = '{8'hDF, 3'd5, 1'b0, 1'b1, 8'h00, 1'b0, 8'hA5, 3'd3};
        tbl[2] = '{8'h02, 3'd1, 1'b0, 1'b0, 8'h02, 1'b1, 8'hA3, 3'd1};
        tbl[3] = '{8'h02, 3'd1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA3, 3'd1};
        tbl[4] = '{8'hFF, 3'd6, 1'b0, 1'b1, 8'h40, 1'b1, 8'hA8, 3'd6};
        tbl[5] = '{8'h00, 3'd6, 1'b1, 1'b1, 8'h00, 1'b0, 8'hA8, 3'd6};
        tbl[6] = '{8'hC0, 3'd0, 1'b1, 1'b1, 8'h40, 1'b1, 8'hA8, 3'd6};
        tbl[7] = '{8'hC0, 3'd0, 1'b1, 1'b1, 8'h80, 1'b1, 8'hA9, 3'd7};
        tbl[8] = '{8'hC0, 3'd0, 1'b1, 1'b1, 8'h40, 1'b1, 8'hA8, 3'd6};

        do_reset();
        for (int t = 0; t < 9; t++) begin
            drive(pat, tbl[t].valid, tbl[t].sel, tbl[t].mode, tbl[t].ordy, '0);
            #1;
            check($sformatf("vec%0d_in_ready", t), mux_if.in_ready, tbl[t].exp_rdy);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out_valid", t), mux_if.out_valid, tbl[t].exp_valid);
            check($sformatf("vec%0d_out_data", t), mux_if.out_data, tbl[t].exp_data);
            check($sformatf("vec%0d_out_ch", t), mux_if.out_ch, tbl[t].exp_ch);
        end

        // All channels valid: round-robin at one beat per cycle
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cycle(pat, 8'hFF, '0, 1'b1, 1'b1, '0);
            check("rr_seq_ch", mux_if.out_ch, k % N);
            check("rr_seq_valid", mux_if.out_valid, 1);
        end

        // Two channels with a stalling consumer
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cycle(pat, 8'h81, '0, 1'b1, ~k[0], '0);
            check("stall_alt_ch", mux_if.out_ch, ((k / 2) % 2 == 1) ? 7 : 0);
        end

        // Asynchronous reset while a stalled beat is held
        drive(pat, 8'hFF, '0, 1'b1, 1'b0, '0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", mux_if.out_valid, 0);
        check("midrst_in_ready", mux_if.in_ready, 0);
        check("midrst_out_data", mux_if.out_data, 0);
        #1;
        rst = 1'b0;
        model_reset();
        cycle(pat, 8'hFF, '0, 1'b1, 1'b1, '0);
        check("midrst_restart_ch", mux_if.out_ch, 0);

`ifdef STREAM_MUX_LOCK_EN
        do_reset();
        cycle(pat, 8'h04, '0, 1'b1, 1'b1, 8'h00);
        check("lock_b1_ch", mux_if.out_ch, 2);
        check("lock_b1_last", mux_if.out_last, 0);
        cycle(pat, 8'h05, '0, 1'b1, 1'b1, 8'h00);
        check("lock_b2_ch", mux_if.out_ch, 2);
        check("lock_b2_last", mux_if.out_last, 0);
        cycle(pat, 8'h05, '0, 1'b1, 1'b1, 8'h04);
        check("lock_b3_ch", mux_if.out_ch, 2);
        check("lock_b3_last", mux_if.out_last, 1);
        cycle(pat, 8'h01, '0, 1'b1, 1'b1, 8'h00);
        check("lock_after_ch", mux_if.out_ch, 0);
        check("lock_after_last", mux_if.out_last, 0);
`endif

        do_reset();
        begin
            logic md;
            md = 1'b1;
            for (int k = 0; k < 600; k++) begin
                if ($urandom_range(0, 15) == 0) md = ~md;
                cycle({$urandom, $urandom}, N'($urandom), SW'($urandom_range(0, N - 1)), md,
                      $urandom_range(0, 3) != 0, N'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stream_mux_n_1.md
Name: stream_mux_n_1

Overview:
- Parametrised N-to-1 multiplexer for W-bit data streams; successor to the 1-bit 8:1 combinational mux.
- Each input channel has a valid/ready handshake.
- Two grant modes, selected at run time: fixed select, or round-robin arbitration.
- The output is registered (one-deep output stage). It sits between multiple producer blocks and a single downstream consumer.

Parameters:
- N_CH, 8, number of input channels (2..32).
- W, 8, data width per channel in bits (1..64).
- SEL_W, $clog2(N_CH), width of the select and channel-ID fields (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N_CH*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready (combinational).
- sel  input  SEL_W  channel select, used in fixed mode.
- mode  input  1  0 = fixed select, 1 = round-robin.
- out_data  output  W  registered output data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts a beat.
- out_ch  output  SEL_W  source channel of the beat in out_data.

Behaviour:
- Reset (asynchronous, active-high):
  - out_valid=0, out_data=0, out_ch=0.
  - rr_ptr=N_CH-1, so the first round-robin search starts at channel 0.
- Load enable: load_en = !out_valid || out_ready. The output register is free, or it is being drained in the same cycle.
- Grant in fixed mode (mode=0):
  - grant = sel when sel < N_CH and in_valid[sel]=1.
  - Otherwise no grant. An out-of-range sel never grants.
- Grant in round-robin mode (mode=1):
  - Search in_valid starting at rr_ptr+1, wrapping modulo N_CH.
  - The first valid channel found wins.
- in_ready[i] = load_en && granted && (grant==i). At most one bit is set per cycle. in_ready never depends on out_data.
- Transfer on channel i: in_valid[i] && in_ready[i] at a clock edge. On the next edge:
  - out_data <= channel i data; out_ch <= i; out_valid <= 1.
  - In round-robin mode, rr_ptr <= i. rr_ptr is not updated in fixed mode.
- Drain: when out_valid && out_ready and there is no new transfer, out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous drain and load: full throughput. A new beat is loaded in the same cycle the old one drains. Sustained rate is 1 beat/cycle.
- Latency: 1 cycle from input transfer to out_valid.
- Backpressure: when out_valid=1 and out_ready=0, all in_ready=0 and out_data/out_ch stay stable.
- A mode or sel change takes effect on the next grant evaluation. A beat already held in the output register is unaffected.
- Wrap-around: with rr_ptr=N_CH-1 the search begins at channel 0. With a single valid channel, that channel wins every cycle.
- Reset asserted mid-stream: the held beat is discarded immediately and no in_ready is issued while rst=1.

Optional Feature:
STREAM_MUX_LOCK_EN
- Defined:
  - Adds port in_last (input, N_CH, marks the last beat of a packet per channel).
  - In round-robin mode, once channel i is granted, the grant is locked to i until a beat with in_last[i]=1 transfers. Other channels receive no in_ready during the lock, even if channel i deasserts valid.
  - rr_ptr updates only on the last beat.
  - Adds output out_last (registered, reset 0), which travels with out_data.
  - Fixed mode ignores the lock.
- Undefined: no in_last/out_last ports; arbitration is per beat as described above.

Test Plan:
- Reset, then mode=0, sel=3, W=8, in_valid=8'h08, ch3 data=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_ch=3; in_ready=8'h08 during the transfer cycle.
- mode=0, sel=5, in_valid[5]=0, other channels valid -> in_ready=0, and out_valid goes 0 after the drain.
- mode=1, in_valid=8'hFF held, out_ready=1 for 10 cycles -> out_ch sequence 0,1,2,3,4,5,6,7,0,1 with out_valid continuously 1.
- mode=1, in_valid=8'h81, out_ready toggled 1,0,1,0 -> out_ch alternates 0,7; while stalled, out_data stays stable and in_ready=0; no beat is lost or duplicated (scoreboard).
- Mid-stream: out_valid=1 with out_ready=0, assert rst for a partial cycle -> out_valid=0 immediately (asynchronous); after release, round-robin restarts at channel 0.
- STREAM_MUX_LOCK_EN: ch2 sends a 3-beat packet (in_last on beat 3) while ch0 is valid -> out_ch 2,2,2,0, with out_last=1 on the third beat only.
